// File: rtl/stream_fork_n.sv
// rtl/stream_fork_n.sv - N-way stream fork with per-channel served tracking,
// optional per-packet destination lock and saturating dropped-beat counter.
module stream_fork_n #(
  parameter int DATA_WD      = 32,
  parameter int N_OUT        = 4,
  parameter int MASK_PER_PKT = 0,
  parameter int CNT_WD       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WD-1:0]       a_data,
  input  logic [N_OUT-1:0]         a_mask,
  input  logic                     a_last,
  input  logic                     a_valid,
  output logic                     a_ready,
  output logic [N_OUT*DATA_WD-1:0] m_data,
  output logic [N_OUT-1:0]         m_last,
  output logic [N_OUT-1:0]         m_valid,
  input  logic [N_OUT-1:0]         m_ready,
  output logic                     busy,
  output logic [CNT_WD-1:0]        drop_cnt
);

  localparam logic [CNT_WD-1:0] CNT_ONE = 1;
  localparam logic [CNT_WD-1:0] CNT_MAX = '1;

  logic [N_OUT-1:0]  served_q, served_d;
  logic [N_OUT-1:0]  held_mask_q, held_mask_d;
  logic              in_pkt_q, in_pkt_d;
  logic [CNT_WD-1:0] drop_cnt_q, drop_cnt_d;

  logic [N_OUT-1:0]  emask, pend, m_fire;
  logic              a_fire, drop;

  assign m_data = {N_OUT{a_data}};
  assign m_last = {N_OUT{a_last}};

  // m_valid is derived only from a_valid and state, never from m_ready.
  always_comb begin
    emask   = (MASK_PER_PKT != 0 && in_pkt_q) ? held_mask_q : a_mask;
    pend    = emask & ~served_q;
    m_valid = {N_OUT{a_valid}} & pend;
    m_fire  = m_valid & m_ready;
    a_ready = &(~pend | m_ready);
    a_fire  = a_valid && a_ready;
    drop    = a_fire && (emask == '0);
  end

  always_comb begin
    served_d    = a_fire ? '0 : (served_q | m_fire);
    in_pkt_d    = in_pkt_q;
    held_mask_d = held_mask_q;
    drop_cnt_d  = drop_cnt_q;
    if (drop && drop_cnt_q != CNT_MAX) begin
      drop_cnt_d = drop_cnt_q + CNT_ONE;
    end
    // Lock captures the raw first-beat mask, so an all-zero first mask drops the whole packet.
    if (MASK_PER_PKT != 0 && a_fire) begin
      if (a_last) begin
        in_pkt_d = 1'b0;
      end else if (!in_pkt_q) begin
        in_pkt_d    = 1'b1;
        held_mask_d = a_mask;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      served_q    <= '0;
      held_mask_q <= '0;
      in_pkt_q    <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      served_q    <= served_d;
      held_mask_q <= held_mask_d;
      in_pkt_q    <= in_pkt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign busy     = |served_q;
  assign drop_cnt = drop_cnt_q;

endmodule
